// File: rtl/slink_axi_pkg.sv
// Shared constants for the SLINK AXI target: packet data types, channel indices
// and header field positions used by the channel formatters and arbiter.
package slink_axi_pkg;

    localparam logic [7:0] DT_AW = 8'h20;
    localparam logic [7:0] DT_W  = 8'h21;
    localparam logic [7:0] DT_B  = 8'h22;
    localparam logic [7:0] DT_AR = 8'h23;
    localparam logic [7:0] DT_R  = 8'h24;

    // Header layout shared by every packed channel packet
    localparam int DT_LSB      = 0;
    localparam int DT_MSB      = 7;
    localparam int WC_LSB      = 8;
    localparam int WC_MSB      = 23;
    localparam int PAYLOAD_LSB = 24;

    localparam int NUM_CH = 3;

    // Order of the enum is the round-robin order
    typedef enum logic [1:0] {
        CH_AW = 2'd0,
        CH_W  = 2'd1,
        CH_AR = 2'd2
    } ch_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slink_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins;
// ptr_nxt names the slot after the winner so it is searched last next time.
module slink_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr_nxt,
    output logic          any_gnt
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        gnt     = '0;
        ptr_nxt = ptr;
        any_gnt = 1'b0;
        for (int off = 0; off < N; off++) begin
            int idx;
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/slink_axi_tgt_chan_arb.sv
// Schedules AW, W and AR packets onto the single A2L path: round-robin with
// W-burst locking, W-after-AW ordering and outstanding-transaction limits.
module slink_axi_tgt_chan_arb
    import slink_axi_pkg::*;
#(
    parameter int PKT_WIDTH       = 105,
    parameter int MAX_WR_OUTSTAND = 8,
    parameter int MAX_RD_OUTSTAND = 8,
    localparam int CNT_W = $clog2(max_int(MAX_WR_OUTSTAND, MAX_RD_OUTSTAND)) + 1
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset,
    input  logic                 enable,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [PKT_WIDTH-1:0] aw_data,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic                 w_last,
    input  logic [PKT_WIDTH-1:0] w_data,
    input  logic                 ar_valid,
    output logic                 ar_ready,
    input  logic [PKT_WIDTH-1:0] ar_data,
    output logic                 a2l_valid,
    input  logic                 a2l_ready,
    output logic [PKT_WIDTH-1:0] a2l_data,
    input  logic                 b_done,
    input  logic                 r_done,
    output logic [CNT_W-1:0]     wr_outstand,
    output logic [CNT_W-1:0]     rd_outstand,
    output logic                 cnt_err
);

    localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(MAX_WR_OUTSTAND);
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(MAX_RD_OUTSTAND);

    ch_e                  rr_ptr;
    logic                 w_lock;
    logic [CNT_W-1:0]     aw_w_debt;
    logic                 load_ok, grant_en;
    logic [NUM_CH-1:0]    req, gnt;
    logic [1:0]           ptr_nxt;
    logic                 any_gnt;
    logic                 aw_gnt, w_gnt, ar_gnt, wlast_gnt;
    logic [PKT_WIDTH-1:0] sel_data;

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        if (inc && !dec)             return c + CNT_W'(1);
        if (dec && !inc && c != '0)  return c - CNT_W'(1);
        return c;
    endfunction

    // Readys are forced low while reset is asserted, even though they are combinational
    assign load_ok  = ~a2l_valid | a2l_ready;
    assign grant_en = load_ok & enable & ~axi_reset;

    assign req[CH_AW] = grant_en & aw_valid & (wr_outstand < WR_MAX)
                        & (aw_w_debt < WR_MAX) & ~w_lock;
    assign req[CH_W]  = grant_en & w_valid & (aw_w_debt != '0);
    assign req[CH_AR] = grant_en & ar_valid & (rd_outstand < RD_MAX) & ~w_lock;

    slink_rr_arbiter #(.N(NUM_CH), .PW(2)) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt),
        .any_gnt (any_gnt)
    );

    assign aw_gnt    = gnt[CH_AW];
    assign w_gnt     = gnt[CH_W];
    assign ar_gnt    = gnt[CH_AR];
    assign wlast_gnt = w_gnt & w_last;
    assign aw_ready  = aw_gnt;
    assign w_ready   = w_gnt;
    assign ar_ready  = ar_gnt;

    always_comb begin
        sel_data = aw_data;
        if (w_gnt)  sel_data = w_data;
        if (ar_gnt) sel_data = ar_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            rr_ptr      <= CH_AW;
            w_lock      <= 1'b0;
            aw_w_debt   <= '0;
            wr_outstand <= '0;
            rd_outstand <= '0;
            cnt_err     <= 1'b0;
            a2l_valid   <= 1'b0;
            a2l_data    <= '0;
        end else begin
            if (any_gnt) rr_ptr <= ch_e'(ptr_nxt);
            if (w_gnt)   w_lock <= ~w_last;

            wr_outstand <= cnt_step(wr_outstand, aw_gnt, b_done);
            rd_outstand <= cnt_step(rd_outstand, ar_gnt, r_done);
            aw_w_debt   <= cnt_step(aw_w_debt, aw_gnt, wlast_gnt);

            // Sticky underflow flag: a completion arrived with nothing outstanding
            if ((b_done && !aw_gnt && wr_outstand == '0) ||
                (r_done && !ar_gnt && rd_outstand == '0) ||
                (wlast_gnt && !aw_gnt && aw_w_debt == '0))
                cnt_err <= 1'b1;

            if (any_gnt) begin
                a2l_valid <= 1'b1;
                a2l_data  <= sel_data;
            end else if (a2l_ready) begin
                a2l_valid <= 1'b0;
            end
        end
    end

endmodule
